mem_arbiter: RTL and testbench

Two-requester controller for the core's single shared memory port. Arbitrates between the fetch stage's instruction port and the memory stage's data port, sequences each access as one outstanding memory transaction, and returns read data with a one-cycle ready pulse. Sits between the pipeline (fetch and memory stages) and the external memory. The fetch stage stalls until its ready arrives; the memory stage does the same.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: memory arbiter FSM state, grant owner and latched request.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port, one outstanding access at a time.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise data always beats fetch.
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  fsm_state
);

    // Handshakes: a port holds req (fields stable) until its one-cycle ready;
    // mem_req stays high until mem_ack or the timeout, whichever comes first.

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    mem_req_t         req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick_d;
    logic             any_req;

    assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_q;

    // On a tie the port that did not win last time gets the grant.
    assign pick_d = d_req & (~i_req | (last_q == OWN_I));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_I;
        end else if (state_q == IDLE && any_req) begin
            last_q <= pick_d ? OWN_D : OWN_I;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_I;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        kill_d  = kill_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (any_req) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (pick_d) begin
                        owner_d     = OWN_D;
                        req_d.we    = d_we;
                        req_d.be    = d_be;
                        req_d.addr  = d_addr;
                        req_d.wdata = d_wdata;
                    end else begin
                        owner_d     = OWN_I;
                        req_d.we    = 1'b0;
                        req_d.be    = BE_FULL;
                        req_d.addr  = i_addr;
                        req_d.wdata = '0;
                    end
                end
            end

            BUSY: begin
                if (owner_q == OWN_I && i_flush) begin
                    kill_d = 1'b1;
                end
                // An ack on the final counted cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = RESP;
                    rdata_d = req_q.we ? 32'h0 : mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = req_q.we;
    assign mem_be    = req_q.be;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    assign i_ready   = (state_q == RESP) && (owner_q == OWN_I) && !kill_q;
    assign d_ready   = (state_q == RESP) && (owner_q == OWN_D);
    assign err       = err_q && (i_ready || d_ready);
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases, random scoreboard run.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import pipeline_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ready, d_ready, err, mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [1:0]  fsm_state;

    logic        auto_mode, man_ack, auto_ack;
    logic [31:0] man_rdata, auto_rdata;
    int          auto_lat, auto_wait;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_i_q[$];
    logic [32:0] exp_d_q[$];

    assign mem_ack   = auto_mode ? auto_ack : man_ack;
    assign mem_rdata = auto_mode ? auto_rdata : man_rdata;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- memory model (random phase) ----------------
    always @(posedge clk) begin
        #1;
        auto_ack   = 1'b0;
        auto_rdata = 32'hFFFF_0000;
        if (mem_req) begin
            auto_wait++;
            if (auto_wait == auto_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = mem_fn(mem_addr);
            end
        end else begin
            auto_wait = 0;
            auto_lat  = $urandom_range(1, 5);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic mon_prev_req, mon_prev_ack;
    int   mon_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            mon_prev_req = 1'b0;
            mon_prev_ack = 1'b0;
            mon_cnt      = 0;
        end else begin
            if (i_ready) begin
                if (exp_i_q.size() == 0) fail_now("i_ready_unexpected");
                else check("i_resp", {err, i_rdata}, exp_i_q.pop_front());
            end
            if (d_ready) begin
                if (exp_d_q.size() == 0) fail_now("d_ready_unexpected");
                else check("d_resp", {err, d_rdata}, exp_d_q.pop_front());
            end
            if (err && !i_ready && !d_ready) check("err_without_ready", err, 1'b0);
            if (mon_prev_req && !mem_req)
                check("mem_req_drop_legal", mon_prev_ack || (mon_cnt == TO), 1'b1);
            mon_cnt      = mem_req ? mon_cnt + 1 : 0;
            mon_prev_req = mem_req;
            mon_prev_ack = mem_ack;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // cycle of mem_req in which ack arrives; 0 = never
        logic [31:0] mem_data;
        logic        flush;     // pulse i_flush in the second mem_req cycle
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [32:0] exp_resp;  // {err, rdata}
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int cyc;
        d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata; i_addr = v.addr;
        if (v.is_d) begin
            exp_d_q.push_back(v.exp_resp);
            d_req = 1'b1;
        end else begin
            exp_i_q.push_back(v.exp_resp);
            i_req = 1'b1;
        end
        tick();
        check({tag, "_mem_req"}, mem_req, 1'b1);
        check({tag, "_mem_addr"}, mem_addr, v.addr);
        check({tag, "_mem_we_be"}, {mem_we, mem_be}, {v.exp_we, v.exp_be});
        if (v.is_d) check({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
        n   = 0;
        cyc = 1;
        while (mem_req && cyc < 40) begin
            n++;
            i_flush = v.flush && (cyc == 2);
            if (v.lat == cyc) begin
                man_ack   = 1'b1;
                man_rdata = v.mem_data;
            end
            tick();
            cyc++;
            man_ack   = 1'b0;
            man_rdata = 32'hFFFF_0000;
            i_flush   = 1'b0;
        end
        check({tag, "_req_cycles"}, n, (v.lat == 0) ? TO : v.lat);
        check({tag, "_ready"}, v.is_d ? d_ready : i_ready, 1'b1);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        check({tag, "_idle"}, fsm_state, IDLE);
    endtask

    task automatic serve(input string tag, input logic port_d, input logic exp_we,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input int lat, input logic [31:0] data);
        int w;
        w = 0;
        while (!mem_req && w < 20) begin
            tick();
            w++;
        end
        if (!mem_req) begin
            fail_now({tag, "_wait_mem_req"});
        end else begin
            check({tag, "_grant"}, {mem_we, mem_be, mem_addr}, {exp_we, exp_be, exp_addr});
            for (int c = 1; c < lat; c++) tick();
            man_ack   = 1'b1;
            man_rdata = data;
            tick();
            man_ack   = 1'b0;
            man_rdata = 32'hFFFF_0000;
            check({tag, "_ready"}, port_d ? d_ready : i_ready, 1'b1);
        end
        if (port_d) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    // ---------------- random drivers ----------------
    task automatic fetch_driver(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int w;
            a = $urandom & 32'hFFFF_FFFC;
            i_addr = a;
            exp_i_q.push_back({1'b0, mem_fn(a)});
            i_req = 1'b1;
            w = 0;
            do begin tick(); w++; end while (!i_ready && w < 100);
            if (!i_ready) fail_now("rand_fetch_wait");
            i_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic data_driver(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            logic we;
            int w;
            a  = $urandom;
            we = 1'($urandom_range(0, 1));
            d_addr = a; d_we = we; d_be = 4'($urandom_range(0, 15)); d_wdata = $urandom;
            exp_d_q.push_back({1'b0, we ? 32'h0 : mem_fn(a)});
            d_req = 1'b1;
            w = 0;
            do begin tick(); w++; end while (!d_ready && w < 100);
            if (!d_ready) fail_now("rand_data_wait");
            d_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic i_first;

        vecs[0] = '{1'b0, 1'b1, 4'h3, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0,
                    1'b0, 4'hF, 32'h0, {1'b0, 32'hDEAD_BEEF}};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h77, 3, 32'h1234_5678, 1'b0,
                    1'b0, 4'hF, 32'h77, {1'b0, 32'h1234_5678}};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'hCAFE_F00D, 2, 32'hFFFF_FFFF, 1'b0,
                    1'b1, 4'h3, 32'hCAFE_F00D, {1'b0, 32'h0}};
        vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b0,
                    1'b0, 4'hF, 32'h0, {1'b1, 32'h0}};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 0, 32'h0, 1'b0,
                    1'b0, 4'hF, 32'h0, {1'b1, 32'h0}};
        vecs[5] = '{1'b0, 1'b1, 4'h5, 32'h0000_0108, 32'h0, TO, 32'h0BAD_F00D, 1'b0,
                    1'b0, 4'hF, 32'h0, {1'b0, 32'h0BAD_F00D}};
        vecs[6] = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFC, 32'h8000_0001, 5, 32'h1212_1212, 1'b1,
                    1'b1, 4'h8, 32'h8000_0001, {1'b0, 32'h0}};
        vecs[7] = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0, 7, 32'hA5A5_A5A5, 1'b0,
                    1'b0, 4'hF, 32'h0, {1'b0, 32'hA5A5_A5A5}};

        rst = 1'b1;
        auto_mode = 1'b0; man_ack = 1'b0; man_rdata = 32'hFFFF_0000;
        i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        #1 rst = 1'b0;
        #1;
        check("reset_outputs",
              {mem_req, mem_we, mem_be, i_ready, d_ready, err, fsm_state}, '0);
        check("reset_buses", {mem_addr, mem_wdata}, '0);
        check("reset_rdata", {i_rdata, d_rdata}, '0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Ack outside BUSY must be ignored.
        man_ack = 1'b1; man_rdata = 32'h1357_9BDF;
        tick();
        man_ack = 1'b0;
        check("stray_ack_state", fsm_state, IDLE);
        check("stray_ack_ready", {i_ready, d_ready}, 2'b00);

        // Flushed fetch: flush in cycle 2, ack in cycle 4, no ready in 5, IDLE in 6.
        i_addr = 32'h200; i_req = 1'b1;
        tick();
        check("flush_mem_req", mem_req, 1'b1);
        tick();
        i_flush = 1'b1; i_req = 1'b0;
        tick();
        i_flush = 1'b0;
        tick();
        man_ack = 1'b1; man_rdata = 32'h1111_2222;
        tick();
        man_ack = 1'b0;
        check("flush_no_ready", {i_ready, err}, 2'b00);
        check("flush_resp_state", fsm_state, RESP);
        tick();
        check("flush_idle", fsm_state, IDLE);
        run_vec(vecs[0], "after_flush");

        // Simultaneous requests.
        do_reset();
        tick();
        i_addr = 32'h500; d_we = 1'b1; d_addr = 32'h2000; d_be = 4'b0011; d_wdata = 32'h55AA;
        exp_d_q.push_back({1'b0, 32'h0});
        exp_i_q.push_back({1'b0, 32'h5000_0001});
        i_req = 1'b1; d_req = 1'b1;
        serve("pair1_first_d", 1'b1, 1'b1, 4'b0011, 32'h2000, 2, 32'hFFFF_FFFF);
        serve("pair1_second_i", 1'b0, 1'b0, 4'hF, 32'h500, 1, 32'h5000_0001);
        d_we = 1'b0; d_addr = 32'h60; d_be = 4'hF;
        exp_d_q.push_back({1'b0, 32'h6000_0006});
        d_req = 1'b1;
        serve("single_d", 1'b1, 1'b0, 4'hF, 32'h60, 1, 32'h6000_0006);
        tick();
`ifdef MEM_ARB_RR_EN
        i_first = 1'b1;
`else
        i_first = 1'b0;
`endif
        i_addr = 32'h504; d_addr = 32'h64;
        exp_d_q.push_back({1'b0, 32'h6400_0064});
        exp_i_q.push_back({1'b0, 32'h5040_0504});
        i_req = 1'b1; d_req = 1'b1;
        if (i_first) begin
            serve("pair2_first_i", 1'b0, 1'b0, 4'hF, 32'h504, 2, 32'h5040_0504);
            serve("pair2_second_d", 1'b1, 1'b0, 4'hF, 32'h64, 3, 32'h6400_0064);
        end else begin
            serve("pair2_first_d", 1'b1, 1'b0, 4'hF, 32'h64, 3, 32'h6400_0064);
            serve("pair2_second_i", 1'b0, 1'b0, 4'hF, 32'h504, 2, 32'h5040_0504);
        end
        tick();

        // Reset in the middle of a transaction.
        d_we = 1'b0; d_addr = 32'h700; d_req = 1'b1;
        tick();
        check("midrst_mem_req_before", mem_req, 1'b1);
        tick();
        #2 rst = 1'b0;
        #1;
        check("midrst_mem_req_async", mem_req, 1'b0);
        check("midrst_state", fsm_state, IDLE);
        d_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_vec(vecs[1], "after_reset");

        // Random traffic through the scoreboard.
        auto_mode = 1'b1;
        fork
            fetch_driver(500);
            data_driver(500);
        join
        repeat (4) tick();
        auto_mode = 1'b0;
        check("final_i_queue_empty", exp_i_q.size(), 0);
        check("final_d_queue_empty", exp_d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
